spi_master: RTL

//  SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames, single chip select.

---
 rtl/spi_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// ============================================================================
//  Module   : spi_master
//  Function : SPI mode-0 master, MSB first, 8-bit frames, one chip select,
//             start/ready byte handshake with optional CS hold between bytes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int SPI_FREQUENCY   = 1000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       cs_hold,
  input  logic       stop,
  output logic       ready,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_sck,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int HALF_DIV = CLOCK_FREQUENCY / (2 * SPI_FREQUENCY);
  localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  if (HALF_DIV < 1) begin : g_half_div_check
    $error("spi_master: HALF_DIV must be >= 1");
  end

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
  localparam logic [2:0] S_END      = 3'd6;
  localparam logic [2:0] S_GAP      = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic             hold_q, hold_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tick;
  logic             accept;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    hold_d     = hold_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tick       = (div_q == DIV_LAST);
    accept     = start && (state_q == S_IDLE || state_q == S_HOLD);

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], spi_miso};
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            // rx_valid is registered so it lines up with the DONE cycle
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            mosi_d    = tx_sr_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_SHIFT_LO;
          end
        end
      end
      S_SHIFT_LO: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], spi_miso};
          state_d = S_SHIFT_HI;
        end
      end
      S_DONE: begin
        state_d = hold_q ? S_HOLD : S_END;
      end
      S_HOLD: begin
        if (accept)    state_d = S_SETUP;
        else if (stop) state_d = S_END;
      end
      S_END: begin
        if (tick) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      tx_sr_d   = tx_data;
      hold_d    = cs_hold;
      bit_cnt_d = 3'd0;
      cs_d      = 1'b0;
      mosi_d    = tx_data[7];
    end

    // every state entry starts a fresh half-period
    if (state_d != state_q || tick) div_d = '0;
    else                            div_d = div_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= 3'd0;
      tx_sr_q    <= 8'h00;
      rx_sr_q    <= 8'h00;
      hold_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      hold_q     <= hold_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign ready    = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy     = (state_q != S_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_sck  = sck_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;

endmodule

`default_nettype wire
